net_resolver: RTL and testbench
===============================

Name: net_resolver

Overview:
- Parametrised, synthesisable model of a multi-driver Verilog net, with 4-state values encoded in 2-state logic.
- Registers N_DRV driver inputs and resolves them per bit under a selectable net kind (wire/wand/wor/tri0/tri1).
- Models initialisation: after reset, a connected net reads x for INIT_CYCLES; an unconnected net reads its default (z or pull).
- Adds conflict detection and counting; used as the reference net model in the semantics-checking testbenches.

Parameters:
- N_DRV, 4, number of drivers (1..16).
- WIDTH, 8, bits per net.
- MODE, NET_WIRE, net kind from net_pkg::net_mode_e: WIRE, WAND, WOR, TRI0, TRI1.
- CONNECTED, '1, N_DRV-bit mask of drivers that exist; 0 means an unconnected net.
- INIT_CYCLES, 2, cycles the init value is held after reset release (0..255).
- CNT_W, 16, width of the conflict counter.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous, active-high reset.
- drv_en  in  N_DRV  driver i enabled; ignored where CONNECTED[i]=0.
- drv_val  in  N_DRV*WIDTH*2  4-state value per driver; driver i occupies slice [i*2*WIDTH +: 2*WIDTH]; bit b is the 2-bit code at [2b+:2].
- clr_conflict  in  1  clears conflict_sticky and conflict_cnt.
- net_val  out  WIDTH*2  resolved 4-state value, registered.
- net_valid  out  1  high once net_val reflects the drivers.
- conflict  out  1  a strong 0/1 clash occurred in the cycle sampled.
- conflict_sticky  out  1  latched conflict.
- conflict_cnt  out  CNT_W  saturating count of conflict cycles.

Behaviour:
- Encoding: 2'b00=0, 2'b01=1, 2'b10=z, 2'b11=x.
- Disabled or unconnected drivers contribute z. An enabled driver may itself drive z.
- WIRE fold, per bit:
  - z with v gives v.
  - 0 with 1 gives x.
  - x with anything gives x.
  - All z gives z.
- WAND: any 0 gives 0. Else any x gives x. Else any 1 gives 1. Else z.
- WOR: any 1 gives 1. Else any x gives x. Else any 0 gives 0. Else z.
- TRI0 / TRI1: WIRE fold, then a resulting z becomes 0 / 1.
- Init value:
  - CONNECTED!=0: all x.
  - Otherwise: all z; all 0 for TRI0; all 1 for TRI1.
- FSM states are INIT and RUN.
  - rst at an edge: state becomes INIT and init_cnt becomes INIT_CYCLES. If INIT_CYCLES=0, state becomes RUN directly.
  - INIT: each edge decrements init_cnt; at init_cnt==1 the next state is RUN. net_val holds the init value and net_valid=0.
  - RUN: each edge registers the resolution of the drv_en/drv_val present at that edge. Latency is 1 cycle, and net_valid=1.
- The first resolved value is registered at edge INIT_CYCLES+1 after the first edge where rst=0.
- Reset values:
  - net_val = init value.
  - net_valid = 0.
  - conflict = 0, conflict_sticky = 0, conflict_cnt = 0.
- Conflict detection:
  - Raised in RUN only, for modes WIRE/TRI0/TRI1, when any bit has at least one enabled driver at 0 and at least one at 1.
  - x inputs are not conflicts.
  - conflict is registered together with net_val.
- Sticky and counter:
  - conflict_sticky is set on conflict.
  - conflict_cnt increments on a conflict cycle and saturates at all-ones (no wrap).
- clr_conflict:
  - In the same cycle as a conflict, the result is sticky=1 and cnt=1.
  - clr_conflict does not affect net_val.
- Reset mid-operation (rst asserted in RUN): the next edge restores the init value, clears the conflict state, and re-enters INIT.
- Driver changes during INIT are ignored and no conflicts are counted; the value at the first RUN edge is used.

Decomposition:
- net_pkg holds:
  - typedef logic4_t (2 bits) and constants L0, L1, LZ, LX.
  - enum net_mode_e.
  - functions resolve_wire, resolve_wand, resolve_wor (pairwise on logic4_t) and init_value(mode, connected).
- Sub-module net_resolve_comb is a purely combinational N_DRV x WIDTH fold producing the resolved vector plus a per-bit clash vector.
- net_resolver holds the FSM, the registers and the counters.

Test Plan:
1. Unconnected init: WIRE, CONNECTED=0, INIT_CYCLES=2, rst 1 cycle. net_val=all 2'b10 (z) for 2 edges, then remains z; net_valid rises at edge 3.
2. Connected init: CONNECTED=4'b0001, drv0 en=1 driving 8'h00. net_val=all x for 2 edges after release, then all 0 at edge 3 with net_valid=1. INIT_CYCLES=0 gives all 0 at edge 1.
3. WIRE conflict: drv0=8'hFF, drv1=8'h0F, both enabled. Bits[7:4]=x, bits[3:0]=1, conflict=1, cnt=1. Holding for 3 cycles gives cnt=3. CNT_W=2 held 5 cycles gives cnt=3 (saturated).
4. WAND/WOR: drv0=8'hF0, drv1=8'h3C. WAND gives 8'h30; WOR gives 8'hFC; conflict stays 0 in both.
5. TRI1 pull and z-driver: drv0 en=1 driving all z, others disabled. net_val=all 1. Same stimulus with TRI0 gives all 0.
6. Clear and reset: conflict and clr_conflict in the same cycle gives sticky=1, cnt=1. rst mid-RUN gives net_val=init, net_valid=0, cnt=0 at the next edge, then INIT repeats.

Source files
------------

// File: rtl/net_pkg.sv
// Shared types and pairwise resolution rules for the 4-state net model.
// A 4-state bit is carried as a 2-bit code: 00=0, 01=1, 10=z, 11=x.
package net_pkg;

    typedef logic [1:0] logic4_t;

    localparam logic4_t L0 = 2'b00;
    localparam logic4_t L1 = 2'b01;
    localparam logic4_t LZ = 2'b10;
    localparam logic4_t LX = 2'b11;

    typedef enum logic [2:0] {
        NET_WIRE,
        NET_WAND,
        NET_WOR,
        NET_TRI0,
        NET_TRI1
    } net_mode_e;

    typedef enum logic {
        ST_INIT,
        ST_RUN
    } state_e;

    function automatic logic4_t resolve_wire(input logic4_t a, input logic4_t b);
        if (a == LZ) return b;
        if (b == LZ) return a;
        if (a == LX || b == LX || a != b) return LX;
        return a;
    endfunction

    function automatic logic4_t resolve_wand(input logic4_t a, input logic4_t b);
        if (a == L0 || b == L0) return L0;
        if (a == LX || b == LX) return LX;
        if (a == L1 || b == L1) return L1;
        return LZ;
    endfunction

    function automatic logic4_t resolve_wor(input logic4_t a, input logic4_t b);
        if (a == L1 || b == L1) return L1;
        if (a == LX || b == LX) return LX;
        if (a == L0 || b == L0) return L0;
        return LZ;
    endfunction

    // Per-bit value shown before the drivers are reflected on the net.
    function automatic logic4_t init_value(input net_mode_e mode, input logic connected);
        if (connected) return LX;
        if (mode == NET_TRI0) return L0;
        if (mode == NET_TRI1) return L1;
        return LZ;
    endfunction

endpackage

// File: rtl/net_resolve_comb.sv
// Combinational N_DRV x WIDTH fold of all drivers into one resolved vector,
// plus a per-bit flag for strong 0/1 clashes in the wire-like net kinds.
module net_resolve_comb
    import net_pkg::*;
#(
    parameter int                N_DRV     = 4,
    parameter int                WIDTH     = 8,
    parameter net_mode_e         MODE      = NET_WIRE,
    parameter logic [N_DRV-1:0]  CONNECTED = '1
) (
    input  logic [N_DRV-1:0]         i_drv_en,
    input  logic [N_DRV*WIDTH*2-1:0] i_drv_val,
    output logic [WIDTH*2-1:0]       o_val,
    output logic [WIDTH-1:0]         o_clash
);

    localparam bit CLASH_MODE = (MODE == NET_WIRE) || (MODE == NET_TRI0) || (MODE == NET_TRI1);

    always_comb begin : p_fold
        logic4_t w_acc;
        logic4_t w_drv;
        logic    w_has0;
        logic    w_has1;
        o_val   = '0;
        o_clash = '0;
        w_acc   = LZ;
        w_drv   = LZ;
        w_has0  = 1'b0;
        w_has1  = 1'b0;
        for (int b = 0; b < WIDTH; b++) begin
            w_acc  = LZ;
            w_has0 = 1'b0;
            w_has1 = 1'b0;
            for (int d = 0; d < N_DRV; d++) begin
                // Absent or disabled drivers float, so they fold in as z.
                w_drv = (i_drv_en[d] && CONNECTED[d]) ? i_drv_val[d*2*WIDTH + 2*b +: 2] : LZ;
                case (MODE)
                    NET_WAND: w_acc = resolve_wand(w_acc, w_drv);
                    NET_WOR:  w_acc = resolve_wor(w_acc, w_drv);
                    default:  w_acc = resolve_wire(w_acc, w_drv);
                endcase
                w_has0 = w_has0 | (w_drv == L0);
                w_has1 = w_has1 | (w_drv == L1);
            end
            if (MODE == NET_TRI0 && w_acc == LZ) w_acc = L0;
            if (MODE == NET_TRI1 && w_acc == LZ) w_acc = L1;
            o_val[2*b +: 2] = w_acc;
            o_clash[b]      = CLASH_MODE && w_has0 && w_has1;
        end
    end

endmodule

// File: rtl/net_resolver.sv
// Registered multi-driver net: INIT/RUN sequencing after reset, resolved value
// register, and conflict flag / sticky / saturating counter.
module net_resolver
    import net_pkg::*;
#(
    parameter int                N_DRV       = 4,
    parameter int                WIDTH       = 8,
    parameter net_mode_e         MODE        = NET_WIRE,
    parameter logic [N_DRV-1:0]  CONNECTED   = '1,
    parameter int                INIT_CYCLES = 2,
    parameter int                CNT_W       = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [N_DRV-1:0]         drv_en,
    input  logic [N_DRV*WIDTH*2-1:0] drv_val,
    input  logic                     clr_conflict,
    output logic [WIDTH*2-1:0]       net_val,
    output logic                     net_valid,
    output logic                     conflict,
    output logic                     conflict_sticky,
    output logic [CNT_W-1:0]         conflict_cnt,
    output state_e                   dbg_state
);

    localparam logic [WIDTH*2-1:0] INIT_VEC = {WIDTH{init_value(MODE, |CONNECTED)}};
    localparam logic [7:0]         INIT_LD  = 8'(INIT_CYCLES);
    localparam state_e             RST_ST   = (INIT_CYCLES == 0) ? ST_RUN : ST_INIT;

    state_e               r_state;
    state_e               w_state_nxt;
    logic [7:0]           r_init_cnt;
    logic [WIDTH*2-1:0]   r_net_val;
    logic                 r_valid;
    logic                 r_conf;
    logic                 r_sticky;
    logic [CNT_W-1:0]     r_cnt;
    logic [WIDTH*2-1:0]   w_res;
    logic [WIDTH-1:0]     w_clash;
    logic                 w_conf_now;

    net_resolve_comb #(
        .N_DRV     (N_DRV),
        .WIDTH     (WIDTH),
        .MODE      (MODE),
        .CONNECTED (CONNECTED)
    ) u_fold (
        .i_drv_en  (drv_en),
        .i_drv_val (drv_val),
        .o_val     (w_res),
        .o_clash   (w_clash)
    );

    always_comb begin
        w_state_nxt = r_state;
        w_conf_now  = 1'b0;
        case (r_state)
            ST_INIT: if (r_init_cnt <= 8'd1) w_state_nxt = ST_RUN;
            ST_RUN:  w_conf_now = |w_clash;
            default: w_state_nxt = ST_INIT;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= RST_ST;
            r_init_cnt <= INIT_LD;
            r_net_val  <= INIT_VEC;
            r_valid    <= 1'b0;
            r_conf     <= 1'b0;
            r_sticky   <= 1'b0;
            r_cnt      <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_conf  <= w_conf_now;
            if (r_state == ST_INIT) begin
                r_init_cnt <= r_init_cnt - 8'd1;
            end else begin
                r_net_val <= w_res;
                r_valid   <= 1'b1;
            end
            // A clear coinciding with a conflict still records that conflict.
            if (clr_conflict) begin
                r_sticky <= w_conf_now;
                r_cnt    <= w_conf_now ? CNT_W'(1) : '0;
            end else if (w_conf_now) begin
                r_sticky <= 1'b1;
                if (r_cnt != '1) r_cnt <= r_cnt + CNT_W'(1);
            end
        end
    end

    assign net_val         = r_net_val;
    assign net_valid       = r_valid;
    assign conflict        = r_conf;
    assign conflict_sticky = r_sticky;
    assign conflict_cnt    = r_cnt;
    assign dbg_state       = r_state;

endmodule

// File: tb/tb_net_resolver.sv
// Ten net_resolver variants share one stimulus stream; a per-bit reference
// model fills an expected queue that is drained after every clock edge.
module tb_net_resolver;
  import net_pkg::*;

  localparam int NI = 10;
  localparam int EW = 36;
  localparam net_mode_e  MODES [NI] = '{NET_WIRE, NET_WIRE, NET_WIRE, NET_WIRE, NET_WIRE,
                                        NET_WAND, NET_WOR, NET_TRI0, NET_TRI1, NET_TRI1};
  localparam logic [3:0] CONNS [NI] = '{4'hF, 4'h0, 4'h1, 4'hF, 4'hF, 4'hF, 4'hF, 4'hF, 4'hF, 4'h0};
  localparam int         INITS [NI] = '{2, 2, 2, 0, 2, 2, 2, 2, 2, 2};
  localparam int         CNTWS [NI] = '{16, 16, 16, 16, 2, 16, 16, 16, 16, 16};
  localparam logic [15:0] ZV = 16'hAAAA;

  // clock / reset block
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        clr = 1'b0;
  logic [3:0]  drv_en = '0;
  logic [63:0] drv_val = '0;
  always #5 clk = ~clk;

  logic [15:0] o_val    [NI];
  logic        o_valid  [NI];
  logic        o_conf   [NI];
  logic        o_sticky [NI];
  logic [15:0] o_cnt    [NI];
  state_e      o_st     [NI];

  for (genvar k = 0; k < NI; k++) begin : g_dut
    logic [CNTWS[k]-1:0] w_cnt;
    net_resolver #(
      .N_DRV(4), .WIDTH(8), .MODE(MODES[k]), .CONNECTED(CONNS[k]),
      .INIT_CYCLES(INITS[k]), .CNT_W(CNTWS[k])
    ) u_dut (
      .clk(clk), .rst(rst), .drv_en(drv_en), .drv_val(drv_val), .clr_conflict(clr),
      .net_val(o_val[k]), .net_valid(o_valid[k]), .conflict(o_conf[k]),
      .conflict_sticky(o_sticky[k]), .conflict_cnt(w_cnt), .dbg_state(o_st[k])
    );
    assign o_cnt[k] = 16'(w_cnt);
  end

  // scoreboard
  logic [EW-1:0] exp_q[$];
  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // reference model state
  bit          m_run    [NI];
  int          m_icnt   [NI];
  logic [15:0] m_val    [NI];
  bit          m_valid  [NI];
  bit          m_conf   [NI];
  bit          m_sticky [NI];
  int          m_cnt    [NI];

  function automatic logic [1:0] ref_bit(input int k, input int b, output bit clash);
    bit h0, h1, hx;
    logic [1:0] c;
    logic [1:0] r;
    h0 = 0; h1 = 0; hx = 0;
    for (int d = 0; d < 4; d++) begin
      if (drv_en[d] && CONNS[k][d]) begin
        c = drv_val[d*16 + 2*b +: 2];
        if (c == 2'b00) h0 = 1;
        if (c == 2'b01) h1 = 1;
        if (c == 2'b11) hx = 1;
      end
    end
    case (MODES[k])
      NET_WAND: r = h0 ? 2'b00 : hx ? 2'b11 : h1 ? 2'b01 : 2'b10;
      NET_WOR:  r = h1 ? 2'b01 : hx ? 2'b11 : h0 ? 2'b00 : 2'b10;
      default:  r = (hx || (h0 && h1)) ? 2'b11 : h0 ? 2'b00 : h1 ? 2'b01 : 2'b10;
    endcase
    if (MODES[k] == NET_TRI0 && r == 2'b10) r = 2'b00;
    if (MODES[k] == NET_TRI1 && r == 2'b10) r = 2'b01;
    clash = h0 && h1 && (MODES[k] != NET_WAND) && (MODES[k] != NET_WOR);
    return r;
  endfunction

  function automatic logic [15:0] init_vec(input int k);
    logic [1:0] c;
    if (CONNS[k] != 0) c = 2'b11;
    else if (MODES[k] == NET_TRI0) c = 2'b00;
    else if (MODES[k] == NET_TRI1) c = 2'b01;
    else c = 2'b10;
    return {8{c}};
  endfunction

  task automatic model_step(input int k);
    logic [15:0] res;
    bit cl, any, conf_now;
    int maxc;
    maxc = (1 << CNTWS[k]) - 1;
    if (rst) begin
      m_val[k] = init_vec(k); m_valid[k] = 0; m_conf[k] = 0;
      m_sticky[k] = 0; m_cnt[k] = 0;
      m_run[k] = (INITS[k] == 0); m_icnt[k] = INITS[k];
    end else begin
      any = 0;
      for (int b = 0; b < 8; b++) begin
        res[2*b +: 2] = ref_bit(k, b, cl);
        any = any | cl;
      end
      conf_now = m_run[k] && any;
      if (m_run[k]) begin
        m_val[k] = res; m_valid[k] = 1;
      end else begin
        if (m_icnt[k] == 1) m_run[k] = 1;
        m_icnt[k]--;
      end
      m_conf[k] = conf_now;
      if (clr) begin
        m_sticky[k] = conf_now; m_cnt[k] = conf_now ? 1 : 0;
      end else if (conf_now) begin
        m_sticky[k] = 1;
        if (m_cnt[k] < maxc) m_cnt[k]++;
      end
    end
    exp_q.push_back({m_run[k], m_val[k], m_valid[k], m_conf[k], m_sticky[k], 16'(m_cnt[k])});
  endtask

  // driver task: one clock of stimulus, model update, then compare all instances
  task automatic step(input logic r, input logic c, input logic [3:0] en, input logic [63:0] dv);
    logic [EW-1:0] e;
    @(negedge clk);
    rst = r; clr = c; drv_en = en; drv_val = dv;
    for (int k = 0; k < NI; k++) model_step(k);
    @(posedge clk);
    #1;
    for (int k = 0; k < NI; k++) begin
      if (exp_q.size() == 0) begin
        check($sformatf("queue_empty[%0d]", k), 32'd0, 32'd1);
      end else begin
        e = exp_q.pop_front();
        check($sformatf("state[%0d]", k),  32'(o_st[k]),     32'(e[35]));
        check($sformatf("val[%0d]", k),    32'(o_val[k]),    32'(e[34:19]));
        check($sformatf("valid[%0d]", k),  32'(o_valid[k]),  32'(e[18]));
        check($sformatf("conf[%0d]", k),   32'(o_conf[k]),   32'(e[17]));
        check($sformatf("sticky[%0d]", k), 32'(o_sticky[k]), 32'(e[16]));
        check($sformatf("cnt[%0d]", k),    32'(o_cnt[k]),    32'(e[15:0]));
      end
    end
  endtask

  function automatic logic [15:0] enc(input logic [7:0] v);
    logic [15:0] r;
    for (int i = 0; i < 8; i++) r[2*i +: 2] = {1'b0, v[i]};
    return r;
  endfunction

  logic [63:0] dv_conf, dv_ao, dv_z, dv_zero, dv_rnd;

  initial begin
    dv_zero = {ZV, ZV, ZV, enc(8'h00)};
    dv_conf = {ZV, ZV, enc(8'h0F), enc(8'hFF)};
    dv_ao   = {ZV, ZV, enc(8'h3C), enc(8'hF0)};
    dv_z    = {ZV, ZV, ZV, ZV};

    // reset, then init sequence with drv0 driving 0
    step(1'b1, 1'b0, 4'b0000, dv_z);
    repeat (4) step(1'b0, 1'b0, 4'b0001, dv_zero);
    // wire conflict held long enough to saturate the 2-bit counter
    repeat (5) step(1'b0, 1'b0, 4'b0011, dv_conf);
    // wand / wor patterns
    repeat (2) step(1'b0, 1'b0, 4'b0011, dv_ao);
    // enabled driver driving z, pulls visible on tri0/tri1
    repeat (2) step(1'b0, 1'b0, 4'b0001, dv_z);
    // clear coinciding with a conflict, then plain conflict, then plain clear
    step(1'b0, 1'b1, 4'b0011, dv_conf);
    step(1'b0, 1'b0, 4'b0011, dv_conf);
    step(1'b0, 1'b1, 4'b0001, dv_zero);
    step(1'b0, 1'b0, 4'b0011, dv_conf);
    // reset mid-run with conflicting drivers: init repeats, nothing counted
    step(1'b1, 1'b0, 4'b0011, dv_conf);
    repeat (4) step(1'b0, 1'b0, 4'b0011, dv_conf);
    // random 4-state traffic with occasional clear and reset
    for (int n = 0; n < 40; n++) begin
      for (int i = 0; i < 32; i++) dv_rnd[2*i +: 2] = 2'($urandom_range(0, 3));
      step(($urandom_range(0, 39) == 0), ($urandom_range(0, 7) == 0),
           4'($urandom_range(0, 15)), dv_rnd);
    end
    if (exp_q.size() != 0) check("queue_leftover", 32'(exp_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
